// File: rtl/max7219_rx.sv
// ---------------------------------------------------------------------------
// max7219_rx
//   Receive-side model of the MAX7219 3-wire serial interface. The SPI pins
//   are oversampled on clk and assembled into 16-bit frames (D15 first). Each
//   frame is decoded into the MAX7219 register set, and the registers drive
//   an 8x8 LED matrix: one row is active per slot, and the columns are
//   PWM-gated by intensity.
//
//   Optional build macro: MAX7219_DOUT_EN
//     defined   - dout is the registered bit shifted out of sreg[15], which
//                 lets devices be cascaded.
//     undefined - dout is tied to 0.
//
// Ports
//   clk, rst_n         system clock and asynchronous active-low reset
//   sclk, din, load_n  SPI inputs, asynchronous to clk
//   dout               cascade serial output
//   frame_vld          one-clk pulse for each accepted 16-bit frame
//   frame_err          one-clk pulse for each short frame (< 16 bits)
//   frame_addr/data    address and data of the last accepted frame
//   rd_addr, rd_data   combinational register read port
//   row_n, col         active-low row select and column data (registered)
// ---------------------------------------------------------------------------
module max7219_rx #(
    parameter int SCAN_DIV    = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       din,
    input  logic       load_n,
    output logic       dout,
    output logic       frame_vld,
    output logic       frame_err,
    output logic [3:0] frame_addr,
    output logic [7:0] frame_data,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] row_n,
    output logic [7:0] col
);

    localparam int SW        = $clog2(SCAN_DIV);
    localparam int SLOT_UNIT = SCAN_DIV / 16;

    // ---------------- input synchronisers ----------------
    // load_n idles high, so its chain resets to 1. Otherwise the first
    // sample after reset would look like a rising edge and raise frame_err.
    logic [SYNC_STAGES-1:0] sclk_sync_q, din_sync_q, load_sync_q;
    logic                   sclk_prev_q, load_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            din_sync_q  <= '0;
            load_sync_q <= '1;
            sclk_prev_q <= 1'b0;
            load_prev_q <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din};
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], load_n};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            load_prev_q <= load_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, din_s, load_s;
    logic sclk_rise, load_rise, load_fall, shift_en;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign load_s    = load_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign load_rise = load_s & ~load_prev_q;
    assign load_fall = ~load_s & load_prev_q;
    // Gate the shift on the previous load_n sample. An sclk rise that lands
    // in the same sample as the load_n rise therefore still shifts, and the
    // latch that follows includes that bit.
    assign shift_en  = sclk_rise & ~load_prev_q;

    // ---------------- shift / latch ----------------
    logic [15:0] sreg_q, sreg_d;
    logic [4:0]  cnt_q, cnt_inc, cnt_d;

    always_comb begin
        sreg_d  = shift_en ? {sreg_q[14:0], din_s} : sreg_q;
        cnt_inc = cnt_q;
        if (shift_en && cnt_q != 5'd16) cnt_inc = cnt_q + 5'd1;
        cnt_d   = (load_rise || load_fall) ? 5'd0 : cnt_inc;
    end

    logic        frame_vld_q, frame_err_q;
    logic [3:0]  frame_addr_q;
    logic [7:0]  frame_data_q;
    logic [7:0][7:0] digit_q;
    logic [7:0]  decode_q;
    logic [3:0]  inten_q;
    logic [2:0]  limit_q;
    logic        shdn_q, test_q;
    logic        wr_en;

    // The post-shift count and register are used here, so a frame whose last
    // bit arrives in the same sample as the load_n rise still counts as full.
    assign wr_en = load_rise && (cnt_inc == 5'd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q       <= '0;
            cnt_q        <= '0;
            frame_vld_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_addr_q <= '0;
            frame_data_q <= '0;
            digit_q      <= '0;
            decode_q     <= '0;
            inten_q      <= '0;
            limit_q      <= '0;
            shdn_q       <= 1'b0;
            test_q       <= 1'b0;
        end else begin
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            frame_vld_q <= wr_en;
            frame_err_q <= load_rise && (cnt_inc != 5'd16);
            if (wr_en) begin
                frame_addr_q <= sreg_d[11:8];
                frame_data_q <= sreg_d[7:0];
                case (sreg_d[11:8])
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: digit_q[3'(sreg_d[11:8] - 4'd1)] <= sreg_d[7:0];
                    4'h9:    decode_q <= sreg_d[7:0];
                    4'hA:    inten_q  <= sreg_d[3:0];
                    4'hB:    limit_q  <= sreg_d[2:0];
                    4'hC:    shdn_q   <= sreg_d[0];
                    4'hF:    test_q   <= sreg_d[0];
                    default: ;
                endcase
            end
        end
    end

    assign frame_vld  = frame_vld_q;
    assign frame_err  = frame_err_q;
    assign frame_addr = frame_addr_q;
    assign frame_data = frame_data_q;

    // ---------------- cascade output ----------------
`ifdef MAX7219_DOUT_EN
    logic dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        dout_q <= 1'b0;
        else if (shift_en) dout_q <= sreg_q[15];
    end
    assign dout = dout_q;
`else
    logic dout_unused;
    assign dout_unused = sreg_q[15];
    assign dout        = 1'b0;
`endif

    // ---------------- read port ----------------
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8: rd_data = digit_q[3'(rd_addr - 4'd1)];
            4'h9:    rd_data = decode_q;
            4'hA:    rd_data = {4'h0, inten_q};
            4'hB:    rd_data = {5'h0, limit_q};
            4'hC:    rd_data = {7'h0, shdn_q};
            4'hF:    rd_data = {7'h0, test_q};
            default: rd_data = 8'h00;
        endcase
    end

    // ---------------- scan counters ----------------
    logic [SW-1:0] slot_q;
    logic [2:0]    row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            row_q  <= '0;
        end else if (slot_q == SW'(SCAN_DIV - 1)) begin
            slot_q <= '0;
            // The >= comparison also pulls the row back to 0 when scan_limit
            // has been lowered below the current row.
            row_q  <= (row_q >= limit_q) ? 3'd0 : row_q + 3'd1;
        end else begin
            slot_q <= slot_q + SW'(1);
        end
    end

    // ---------------- row / column drive ----------------
    logic [31:0] duty_w;
    logic        pwm_on;
    logic [7:0]  onehot, row_n_d, col_d, row_n_q, col_q;

    assign duty_w = (32'(inten_q) + 32'd1) * 32'(SLOT_UNIT);
    assign pwm_on = 32'(slot_q) < duty_w;
    assign onehot = 8'b1 << row_q;

    always_comb begin
        row_n_d = 8'hFF;
        col_d   = 8'h00;
        if (test_q) begin
            row_n_d = ~onehot;
            col_d   = 8'hFF;
        end else if (shdn_q) begin
            row_n_d = ~onehot;
            col_d   = pwm_on ? digit_q[row_q] : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_n_q <= 8'hFF;
            col_q   <= 8'h00;
        end else begin
            row_n_q <= row_n_d;
            col_q   <= col_d;
        end
    end

    assign row_n = row_n_q;
    assign col   = col_q;

endmodule
